cc_register_hub: RTL and testbench

- Parametrised successor to the Nexys4 command & control hub. Sits between the PicoBlaze port bus and the LogCap core, the UART FIFOs and the board IO.
- Adds a configurable LogCap register count and read-back of written registers.
- Adds a maskable multi-source interrupt controller with an internal periodic tick, an interrupt_ack handshake, and deterministic zero reads on unmapped ports.

---
 rtl/cc_hub_pkg.sv | 27 ++
 rtl/cc_irq_ctrl.sv | 89 ++++++++
 rtl/cc_register_hub.sv | 135 +++++++++++++
 tb/tb_cc_register_hub.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_hub_pkg.sv
// Shared constants for the command & control hub: port map and IRQ state encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package cc_hub_pkg;

    // Port addresses on the PicoBlaze port bus
    localparam logic [7:0] PA_REG_BASE = 8'h00;  // LogCap reg_in read / reg_out write
    localparam logic [7:0] PA_RB_BASE  = 8'h40;  // reg_out read-back
    localparam logic [7:0] PA_CMD      = 8'h20;  // read status, write command
    localparam logic [7:0] PA_UART     = 8'h21;  // read RX data, write TX data
    localparam logic [7:0] PA_USTAT    = 8'h22;  // UART FIFO flags
    localparam logic [7:0] PA_SW_LO    = 8'h23;
    localparam logic [7:0] PA_SW_HI    = 8'h24;
    localparam logic [7:0] PA_BTN      = 8'h25;
    localparam logic [7:0] PA_IRQ_PEND = 8'h26;  // read pending, write-1-to-clear
    localparam logic [7:0] PA_IRQ_MASK = 8'h27;
    localparam logic [7:0] PA_LED_LO   = 8'h28;
    localparam logic [7:0] PA_LED_HI   = 8'h29;

    // Interrupt request handshake states
    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/cc_irq_ctrl.sv
// Interrupt controller: periodic tick, rising-edge sources, pending/mask, request/ack FSM.
// Latency: source edge -> pending 2 cycles; pending&mask -> interrupt 1 cycle.
// Backpressure: none; requests stay pending until cleared by a W1C write.
module cc_irq_ctrl #(
    parameter int N_EXT_IRQ = 3,
    parameter int TICK_DIV  = 100_000_000
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [((N_EXT_IRQ > 0) ? N_EXT_IRQ : 1)-1:0] irq_src,
    input  logic                                      interrupt_ack,
    input  logic                                      pend_wr,
    input  logic                                      mask_wr,
    input  logic [N_EXT_IRQ:0]                        wdata,
    output logic [7:0]                                pending,
    output logic [7:0]                                mask,
    output logic                                      interrupt
);
    import cc_hub_pkg::*;

    localparam int NP = N_EXT_IRQ + 1;
    localparam int SW = (N_EXT_IRQ > 0) ? N_EXT_IRQ : 1;
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [SW-1:0] src_q, src_prev_q;
    logic [NP-1:0] set_req;
    logic [NP-1:0] pending_q, pending_d;
    logic [NP-1:0] mask_q, mask_d;
    irq_state_e    state_q, state_d;
    logic          interrupt_q;

    assign tick       = (tick_cnt_q == TICK_MAX);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // Collect set requests: bit 0 from the tick wrap, bit k+1 from a rising edge of source k
    always_comb begin
        set_req    = '0;
        set_req[0] = tick;
        for (int k = 0; k < N_EXT_IRQ; k++) begin
            set_req[k+1] = src_q[k] & ~src_prev_q[k];
        end
    end

    // Pending: W1C clear first, then OR in new requests so a same-cycle set wins
    always_comb begin
        pending_d = (pending_q & ~(pend_wr ? wdata : '0)) | set_req;
        mask_d    = mask_wr ? wdata : mask_q;
    end

    // Request/ack handshake next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE:    if (|(pending_q & mask_q)) state_d = IRQ_REQ;
            IRQ_REQ:     if (interrupt_ack)         state_d = IRQ_SERVICE;
            IRQ_SERVICE: if (pend_wr)               state_d = IRQ_IDLE;
            default:                                state_d = IRQ_IDLE;
        endcase
    end

    // State, counters and the registered interrupt output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q  <= '0;
            src_q       <= '0;
            src_prev_q  <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            state_q     <= IRQ_IDLE;
            interrupt_q <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            src_q       <= irq_src;
            src_prev_q  <= src_q;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            state_q     <= state_d;
            interrupt_q <= (state_d == IRQ_REQ);
        end
    end

    assign pending   = 8'(pending_q);
    assign mask      = 8'(mask_q);
    assign interrupt = interrupt_q;

endmodule

// File: rtl/cc_register_hub.sv
// PicoBlaze port-bus hub: address decode, LogCap/UART/board IO datapath, interrupt controller.
// Latency: reads 1 cycle after port_id; strobes/pops 1 cycle after the access; TX push combinational.
// Backpressure: none; FIFO flags are only reported to software, never used to stall.
module cc_register_hub #(
    parameter int NUM_REGS  = 8,
    parameter int N_EXT_IRQ = 3,
    parameter int TICK_DIV  = 100_000_000
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [7:0]                                port_id,
    input  logic [7:0]                                port_out,
    output logic [7:0]                                port_in,
    input  logic                                      write_strobe,
    input  logic                                      kwrite_strobe,
    input  logic                                      read_strobe,
    output logic                                      interrupt,
    input  logic                                      interrupt_ack,
    input  logic [((N_EXT_IRQ > 0) ? N_EXT_IRQ : 1)-1:0] irq_src,
    output logic [15:0]                               led,
    input  logic [15:0]                               switch,
    input  logic [7:0]                                button,
    input  logic [7:0]                                data_rx,
    input  logic                                      urx_buffer_full,
    input  logic                                      urx_buffer_half_full,
    input  logic                                      urx_buffer_data_present,
    output logic                                      urx_buffer_read,
    output logic [7:0]                                data_tx,
    input  logic                                      utx_buffer_full,
    input  logic                                      utx_buffer_half_full,
    input  logic                                      utx_buffer_data_present,
    output logic                                      utx_buffer_write,
    input  logic [NUM_REGS*8-1:0]                     reg_in,
    output logic [NUM_REGS*8-1:0]                     reg_out,
    output logic [7:0]                                command,
    output logic                                      command_strobe,
    input  logic [7:0]                                status
);
    import cc_hub_pkg::*;

    logic                  wr;
    logic [NUM_REGS*8-1:0] reg_out_q, reg_out_d;
    logic [15:0]           led_q, led_d;
    logic [7:0]            command_q, command_d;
    logic                  cmd_strobe_q;
    logic                  urx_read_q;
    logic [7:0]            port_in_q, rdata_d;
    logic [7:0]            irq_pending, irq_mask;

    // Constant-port writes behave exactly like normal writes
    assign wr               = write_strobe | kwrite_strobe;
    assign utx_buffer_write = wr && (port_id == PA_UART);
    assign data_tx          = port_out;

    // Next-state for the software-writable registers; unmapped writes fall through
    always_comb begin
        reg_out_d = reg_out_q;
        led_d     = led_q;
        command_d = command_q;
        if (wr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (port_id == PA_REG_BASE + 8'(i)) reg_out_d[8*i +: 8] = port_out;
            end
            if (port_id == PA_LED_LO) led_d[7:0]  = port_out;
            if (port_id == PA_LED_HI) led_d[15:8] = port_out;
            if (port_id == PA_CMD)    command_d   = port_out;
        end
    end

    // Read mux over the full 8-bit address; anything unmapped reads as zero
    always_comb begin
        rdata_d = 8'h00;
        case (port_id)
            PA_CMD:      rdata_d = status;
            PA_UART:     rdata_d = data_rx;
            PA_USTAT:    rdata_d = {2'b00, urx_buffer_full, urx_buffer_half_full,
                                    urx_buffer_data_present, utx_buffer_full,
                                    utx_buffer_half_full, utx_buffer_data_present};
            PA_SW_LO:    rdata_d = switch[7:0];
            PA_SW_HI:    rdata_d = switch[15:8];
            PA_BTN:      rdata_d = button;
            PA_IRQ_PEND: rdata_d = irq_pending;
            PA_IRQ_MASK: rdata_d = irq_mask;
            default: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (port_id == PA_REG_BASE + 8'(i)) rdata_d = reg_in[8*i +: 8];
                    if (port_id == PA_RB_BASE + 8'(i))  rdata_d = reg_out_q[8*i +: 8];
                end
            end
        endcase
    end

    // Datapath registers, registered read data and the one-cycle strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_out_q    <= '0;
            led_q        <= '0;
            command_q    <= '0;
            cmd_strobe_q <= 1'b0;
            urx_read_q   <= 1'b0;
            port_in_q    <= '0;
        end else begin
            reg_out_q    <= reg_out_d;
            led_q        <= led_d;
            command_q    <= command_d;
            cmd_strobe_q <= wr && (port_id == PA_CMD);
            urx_read_q   <= read_strobe && (port_id == PA_UART);
            port_in_q    <= rdata_d;
        end
    end

    cc_irq_ctrl #(
        .N_EXT_IRQ (N_EXT_IRQ),
        .TICK_DIV  (TICK_DIV)
    ) u_irq (
        .clk           (clk),
        .reset         (reset),
        .irq_src       (irq_src),
        .interrupt_ack (interrupt_ack),
        .pend_wr       (wr && (port_id == PA_IRQ_PEND)),
        .mask_wr       (wr && (port_id == PA_IRQ_MASK)),
        .wdata         (port_out[N_EXT_IRQ:0]),
        .pending       (irq_pending),
        .mask          (irq_mask),
        .interrupt     (interrupt)
    );

    assign reg_out         = reg_out_q;
    assign led             = led_q;
    assign command         = command_q;
    assign command_strobe  = cmd_strobe_q;
    assign urx_buffer_read = urx_read_q;
    assign port_in         = port_in_q;

endmodule

// File: tb/tb_cc_register_hub.sv
// Directed bench for cc_register_hub with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
// TICK_DIV is shortened to 10 so tick interrupts happen within a few cycles.
module tb_cc_register_hub;

    localparam int NUM_REGS  = 8;
    localparam int N_EXT_IRQ = 3;
    localparam int TICK_DIV  = 10;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [7:0]            port_id, port_out, port_in;
    logic                  write_strobe, kwrite_strobe, read_strobe;
    logic                  interrupt, interrupt_ack;
    logic [N_EXT_IRQ-1:0]  irq_src;
    logic [15:0]           led, switch;
    logic [7:0]            button, data_rx, data_tx, command, status;
    logic                  urx_buffer_full, urx_buffer_half_full, urx_buffer_data_present, urx_buffer_read;
    logic                  utx_buffer_full, utx_buffer_half_full, utx_buffer_data_present, utx_buffer_write;
    logic [NUM_REGS*8-1:0] reg_in, reg_out;
    logic                  command_strobe;

    int n_checks = 0;
    int n_fail   = 0;
    int wait_cyc;

    cc_register_hub #(
        .NUM_REGS  (NUM_REGS),
        .N_EXT_IRQ (N_EXT_IRQ),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .port_id                 (port_id),
        .port_out                (port_out),
        .port_in                 (port_in),
        .write_strobe            (write_strobe),
        .kwrite_strobe           (kwrite_strobe),
        .read_strobe             (read_strobe),
        .interrupt               (interrupt),
        .interrupt_ack           (interrupt_ack),
        .irq_src                 (irq_src),
        .led                     (led),
        .switch                  (switch),
        .button                  (button),
        .data_rx                 (data_rx),
        .urx_buffer_full         (urx_buffer_full),
        .urx_buffer_half_full    (urx_buffer_half_full),
        .urx_buffer_data_present (urx_buffer_data_present),
        .urx_buffer_read         (urx_buffer_read),
        .data_tx                 (data_tx),
        .utx_buffer_full         (utx_buffer_full),
        .utx_buffer_half_full    (utx_buffer_half_full),
        .utx_buffer_data_present (utx_buffer_data_present),
        .utx_buffer_write        (utx_buffer_write),
        .reg_in                  (reg_in),
        .reg_out                 (reg_out),
        .command                 (command),
        .command_strobe          (command_strobe),
        .status                  (status)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_port(input logic [7:0] addr, input logic [7:0] data);
        port_id      = addr;
        port_out     = data;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [7:0] msk,
                          input logic [7:0] exp);
        port_id = addr;
        step();
        check_eq(tag, port_in & msk, exp);
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        port_id       = 8'h00;
        port_out      = 8'h00;
        write_strobe  = 1'b0;
        kwrite_strobe = 1'b0;
        read_strobe   = 1'b0;
        interrupt_ack = 1'b0;
        irq_src       = '0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        switch                  = 16'hBEEF;
        button                  = 8'h81;
        data_rx                 = 8'h6D;
        status                  = 8'h96;
        urx_buffer_full         = 1'b1;
        urx_buffer_half_full    = 1'b0;
        urx_buffer_data_present = 1'b1;
        utx_buffer_full         = 1'b0;
        utx_buffer_half_full    = 1'b1;
        utx_buffer_data_present = 1'b1;
        reg_in                  = '0;
        reg_in[31:24]           = 8'hC3;
        reg_in[63:56]           = 8'h7E;

        // ---- reset state and register map ----
        do_reset();
        check_eq("rst_port_in", port_in, 8'h00);
        check_eq("rst_interrupt", interrupt, 1'b0);
        check_eq("rst_reg_out", reg_out, 0);
        check_eq("rst_led", led, 16'h0000);
        check_eq("rst_cmd_strobe", command_strobe, 1'b0);

        wr_port(8'h03, 8'h5A);
        check_eq("reg_out3", reg_out[31:24], 8'h5A);
        rd_chk("readback_43", 8'h43, 8'hFF, 8'h5A);
        rd_chk("reg_in_03", 8'h03, 8'hFF, 8'hC3);
        rd_chk("reg_in_07_top", 8'h07, 8'hFF, 8'h7E);
        rd_chk("unmapped_7f", 8'h7F, 8'hFF, 8'h00);
        rd_chk("unmapped_08", 8'h08, 8'hFF, 8'h00);
        wr_port(8'h08, 8'hFF);
        check_eq("unmapped_wr_08", reg_out, 64'h0000_0000_5A00_0000);
        rd_chk("unmapped_48", 8'h48, 8'hFF, 8'h00);
        rd_chk("uart_status", 8'h22, 8'hFF, 8'h2B);
        rd_chk("switch_lo", 8'h23, 8'hFF, 8'hEF);
        rd_chk("switch_hi", 8'h24, 8'hFF, 8'hBE);
        rd_chk("button", 8'h25, 8'hFF, 8'h81);
        rd_chk("status", 8'h20, 8'hFF, 8'h96);
        wr_port(8'h28, 8'hA5);
        wr_port(8'h29, 8'h3C);
        check_eq("led", led, 16'h3CA5);

        // TX push is combinational on the write cycle only
        port_id = 8'h21; port_out = 8'h99; write_strobe = 1'b1;
        #1;
        check_eq("utx_write_hi", utx_buffer_write, 1'b1);
        check_eq("data_tx", data_tx, 8'h99);
        step();
        write_strobe = 1'b0;
        #1;
        check_eq("utx_write_lo", utx_buffer_write, 1'b0);

        // ---- back-to-back command writes ----
        port_id = 8'h20; port_out = 8'h11; kwrite_strobe = 1'b1;
        step();
        check_eq("cmd_strobe_1", command_strobe, 1'b1);
        check_eq("command_1", command, 8'h11);
        kwrite_strobe = 1'b0; port_out = 8'h22; write_strobe = 1'b1;
        step();
        check_eq("cmd_strobe_2", command_strobe, 1'b1);
        check_eq("command_2", command, 8'h22);
        write_strobe = 1'b0;
        step();
        check_eq("cmd_strobe_off", command_strobe, 1'b0);
        check_eq("command_hold", command, 8'h22);

        // ---- tick interrupt, ack and W1C ----
        do_reset();
        wr_port(8'h27, 8'h01);
        wait_cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (interrupt) begin
                wait_cyc = i;
                break;
            end
        end
        check_eq("tick_irq_latency", wait_cyc, 10);
        rd_chk("tick_pending", 8'h26, 8'hFF, 8'h01);
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        check_eq("irq_after_ack", interrupt, 1'b0);
        wr_port(8'h26, 8'h01);
        rd_chk("pending_cleared", 8'h26, 8'hFF, 8'h00);
        repeat (3) step();
        check_eq("irq_stays_low", interrupt, 1'b0);
        wait_cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (interrupt) begin
                wait_cyc = i;
                break;
            end
        end
        check_eq("next_tick_irq", wait_cyc, 3);

        // ---- same-cycle set and W1C: set wins ----
        do_reset();
        irq_src = 3'b001;
        step();
        wr_port(8'h26, 8'h02);
        rd_chk("set_wins", 8'h26, 8'h02, 8'h02);
        wr_port(8'h26, 8'h02);
        rd_chk("w1c_clears", 8'h26, 8'h02, 8'h00);

        // ---- masked source, then unmask ----
        irq_src = 3'b011;
        repeat (2) step();
        rd_chk("src1_pending", 8'h26, 8'h04, 8'h04);
        check_eq("masked_no_irq", interrupt, 1'b0);
        rd_chk("mask_zero", 8'h27, 8'hFF, 8'h00);
        wr_port(8'h27, 8'hFF);
        wait_cyc = 0;
        for (int i = 1; i <= 2; i++) begin
            step();
            if (interrupt) begin
                wait_cyc = i;
                break;
            end
        end
        check_eq("unmask_irq_within_2", (wait_cyc >= 1) && (wait_cyc <= 2), 1'b1);
        rd_chk("mask_upper_zero", 8'h27, 8'hFF, 8'h0F);

        // ---- back-to-back RX pops ----
        port_id = 8'h21; read_strobe = 1'b1;
        step();
        check_eq("urx_read_1", urx_buffer_read, 1'b1);
        step();
        check_eq("urx_read_2", urx_buffer_read, 1'b1);
        check_eq("rx_data", port_in, 8'h6D);
        read_strobe = 1'b0;
        step();
        check_eq("urx_read_off", urx_buffer_read, 1'b0);

        // ---- asynchronous reset while requesting ----
        check_eq("irq_before_reset", interrupt, 1'b1);
        reset   = 1'b0;
        irq_src = '0;
        #1;
        check_eq("async_rst_irq", interrupt, 1'b0);
        check_eq("async_rst_port_in", port_in, 8'h00);
        step();
        reset = 1'b1;
        rd_chk("pending_after_reset", 8'h26, 8'hFF, 8'h00);
        check_eq("irq_after_reset", interrupt, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
